// File: rtl/trivium_stream_engine.sv
`default_nettype none
// ============================================================================
// Module  : trivium_stream_engine
// Brief   : Three-register 64-bit stream cipher engine with seeded warm-up and
//           valid/ready word streaming (XOR or raw keystream output).
// Revision: 1.0 - initial release
// ============================================================================
module trivium_stream_engine #(
    parameter int DATA_W = 8,
    parameter int SEED_W = 8,
    parameter int WARMUP = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_clear_i,
    input  logic              cmd_load_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              mode_ks_only_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              seeded_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WARM  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_GEN   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    localparam logic [63:0]       S1_INIT   = 64'h23A2B;
    localparam logic [63:0]       S2_INIT   = 64'h2A892;
    localparam logic [63:0]       S3_INIT   = 64'hF4511;
    localparam logic [31:0]       P_FULL    = 32'hA5A5A5A5;
    localparam logic [SEED_W-1:0] SEED_P    = P_FULL[SEED_W-1:0];
    localparam logic [7:0]        WARM_LAST = 8'(WARMUP - 1);
    localparam logic [7:0]        BIT_LAST  = 8'(DATA_W - 1);

    logic [2:0]        state_q, state_d;
    logic [63:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] ks_q, ks_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic              seeded_q, seeded_d;

    logic              w_z, w_f1, w_f2, w_f3, w_load;
    logic [DATA_W-1:0] w_ks_shift;

    assign w_z  = s1_q[0] ^ s2_q[0] ^ s3_q[0];
    assign w_f1 = s2_q[0] ^ s3_q[1] ^ s1_q[5] ^ s2_q[7] ^ s3_q[13] ^ s1_q[31] ^ s2_q[47] ^ s3_q[60];
    assign w_f2 = s3_q[3] ^ s1_q[1] ^ s2_q[2] ^ s3_q[19] ^ s1_q[23];
    assign w_f3 = s1_q[5] ^ s2_q[2] ^ s3_q[4] ^ s1_q[17] ^ s2_q[29] ^ s3_q[63] ^ s1_q[10] ^ s2_q[40];
    // First keystream bit of a word ends up in the MSB.
    assign w_ks_shift = DATA_W'({ks_q, w_z});
    assign w_load = cmd_load_i && (seed_i != '0) && ((state_q == ST_IDLE) || (state_q == ST_READY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s1_q       <= S1_INIT;
            s2_q       <= S2_INIT;
            s3_q       <= S3_INIT;
            cnt_q      <= '0;
            data_q     <= '0;
            mode_q     <= 1'b0;
            ks_q       <= '0;
            m_data_q   <= '0;
            word_cnt_q <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            seeded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            ks_q       <= ks_d;
            m_data_q   <= m_data_d;
            word_cnt_q <= word_cnt_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            seeded_q   <= seeded_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        s3_d       = s3_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        mode_d     = mode_q;
        ks_d       = ks_q;
        m_data_d   = m_data_q;
        word_cnt_d = word_cnt_q;
        if (cmd_clear_i) begin
            state_d    = ST_IDLE;
            s1_d       = S1_INIT;
            s2_d       = S2_INIT;
            s3_d       = S3_INIT;
            cnt_d      = '0;
            m_data_d   = '0;
            word_cnt_d = '0;
        end else if (w_load) begin
            s1_d       = 64'({seed_i, seed_i});
            s2_d       = 64'({seed_i, ~seed_i});
            s3_d       = 64'({seed_i, seed_i ^ SEED_P});
            cnt_d      = '0;
            word_cnt_d = '0;
            state_d    = (WARMUP == 0) ? ST_READY : ST_WARM;
        end else begin
            case (state_q)
                ST_WARM: begin
                    s1_d  = {s1_q[62:0], w_f1};
                    s2_d  = {s2_q[62:0], w_f2};
                    s3_d  = {s3_q[62:0], w_f3};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WARM_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (s_valid_i && s_ready_q) begin
                        data_d  = s_data_i;
                        mode_d  = mode_ks_only_i;
                        ks_d    = '0;
                        cnt_d   = '0;
                        state_d = ST_GEN;
                    end
                end
                ST_GEN: begin
                    s1_d  = {s1_q[62:0], w_f1};
                    s2_d  = {s2_q[62:0], w_f2};
                    s3_d  = {s3_q[62:0], w_f3};
                    ks_d  = w_ks_shift;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == BIT_LAST) begin
                        m_data_d = (mode_q ? '0 : data_q) ^ w_ks_shift;
                        cnt_d    = '0;
                        state_d  = ST_OUT;
                    end
                end
                ST_OUT: begin
                    // Registers stay frozen while the consumer stalls.
                    if (m_ready_i) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        state_d    = ST_READY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready_d = (state_d == ST_READY);
        m_valid_d = (state_d == ST_OUT);
        seeded_d  = (state_d == ST_READY) || (state_d == ST_GEN) || (state_d == ST_OUT);
    end

    assign s_ready_o  = s_ready_q;
    assign m_valid_o  = m_valid_q;
    assign m_data_o   = m_data_q;
    assign seeded_o   = seeded_q;
    assign word_cnt_o = word_cnt_q;

endmodule
`default_nettype wire
